// File: rtl/riscuinho_pkg.sv
// Shared definitions for the multi-cycle core sequencer: RV32I opcodes, FSM state
// codes, register write-back source selects and opcode classes (ILLEGAL_TRAP_EN adds TRAP).
package riscuinho_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [1:0] RDS_ALU = 2'b00;
    localparam logic [1:0] RDS_MEM = 2'b01;
    localparam logic [1:0] RDS_PC4 = 2'b10;
    localparam logic [1:0] RDS_IMM = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
`ifdef ILLEGAL_TRAP_EN
        , ST_TRAP = 3'd5
`endif
    } state_e;

    typedef enum logic [3:0] {
        CLS_OP,
        CLS_OP_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_MISC_MEM,
        CLS_SYSTEM,
        CLS_ILLEGAL
    } op_class_e;

    function automatic logic [1:0] rd_src_of(op_class_e cls);
        case (cls)
            CLS_LOAD:           rd_src_of = RDS_MEM;
            CLS_JAL, CLS_JALR:  rd_src_of = RDS_PC4;
            CLS_LUI:            rd_src_of = RDS_IMM;
            default:            rd_src_of = RDS_ALU;
        endcase
    endfunction

    function automatic logic writes_rd(op_class_e cls);
        case (cls)
            CLS_OP, CLS_OP_IMM, CLS_LOAD, CLS_LUI,
            CLS_AUIPC, CLS_JAL, CLS_JALR: writes_rd = 1'b1;
            default:                      writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction- and data-memory request/acknowledge signals of the core sequencer.
// Handshake: a req is held high until the matching ack is seen in the same cycle; ack without req is ignored.
interface core_sequencer_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ack, dmem_ack
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ack, dmem_ack
    );
endinterface

// File: rtl/seq_op_class.sv
// Combinational opcode classifier: maps instr[6:0] to an opcode class and a legal flag.
module seq_op_class
    import riscuinho_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_e  op_class,
    output logic       legal
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        legal    = 1'b1;
        case (opcode)
            OPC_OP:       op_class = CLS_OP;
            OPC_OP_IMM:   op_class = CLS_OP_IMM;
            OPC_LOAD:     op_class = CLS_LOAD;
            OPC_STORE:    op_class = CLS_STORE;
            OPC_BRANCH:   op_class = CLS_BRANCH;
            OPC_JAL:      op_class = CLS_JAL;
            OPC_JALR:     op_class = CLS_JALR;
            OPC_LUI:      op_class = CLS_LUI;
            OPC_AUIPC:    op_class = CLS_AUIPC;
            OPC_MISC_MEM: op_class = CLS_MISC_MEM;
            OPC_SYSTEM:   op_class = CLS_SYSTEM;
            default:      legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for a small RV32I core.
// Define ILLEGAL_TRAP_EN to send unknown opcodes to a sticky TRAP state instead of retiring them as NOPs.
module core_sequencer
    import riscuinho_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd_sel,
    input  logic              branch_taken,
    core_sequencer_if.master  bus,
    output logic              ir_we,
    output logic              pc_we,
    output logic              pc_src,
    output logic              rf_we,
    output logic [1:0]        rd_data_sel,
    output logic              instret,
    output logic [2:0]        state_dbg,
    output logic              trap
);

    state_e    state, state_nx;
    op_class_e cls_q;
    op_class_e cls_d;
    logic      legal_d;
    logic      rd_nz_q;
    logic      run_q;
    logic      imem_req, dmem_req, dmem_we;

    seq_op_class u_op_class (
        .opcode   (opcode),
        .op_class (cls_d),
        .legal    (legal_d)
    );

`ifndef ILLEGAL_TRAP_EN
    logic unused_legal;
    assign unused_legal = legal_d;
`endif

    // run_q stays low for the first cycle out of reset so every output is 0 while reset is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_FETCH;
            cls_q   <= CLS_OP;
            rd_nz_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state <= state_nx;
            run_q <= 1'b1;
            if (state == ST_DECODE) begin
                cls_q   <= cls_d;
                rd_nz_q <= |rd_sel;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 1'b0;
        rf_we       = 1'b0;
        rd_data_sel = RDS_ALU;
        instret     = 1'b0;
        trap        = 1'b0;
        if (run_q) begin
            case (state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (bus.imem_ack) begin
                        ir_we    = 1'b1;
                        state_nx = ST_DECODE;
                    end
                end
                ST_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                    state_nx = legal_d ? ST_EXEC : ST_TRAP;
`else
                    state_nx = ST_EXEC;
`endif
                end
                ST_EXEC: begin
                    rd_data_sel = rd_src_of(cls_q);
                    state_nx    = (cls_q == CLS_LOAD || cls_q == CLS_STORE) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    rd_data_sel = rd_src_of(cls_q);
                    dmem_req    = 1'b1;
                    dmem_we     = (cls_q == CLS_STORE);
                    if (bus.dmem_ack) state_nx = ST_WB;
                end
                ST_WB: begin
                    rd_data_sel = rd_src_of(cls_q);
                    pc_we       = 1'b1;
                    instret     = 1'b1;
                    rf_we       = writes_rd(cls_q) && rd_nz_q;
                    // Branch outcome is taken live here; the comparator result is valid in WB.
                    case (cls_q)
                        CLS_JAL, CLS_JALR: pc_src = 1'b1;
                        CLS_BRANCH:        pc_src = branch_taken;
                        default:           pc_src = 1'b0;
                    endcase
                    state_nx = ST_FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                ST_TRAP: begin
                    trap = 1'b1;
                end
`endif
                default: state_nx = ST_FETCH;
            endcase
        end
    end

    assign bus.imem_req = imem_req;
    assign bus.dmem_req = dmem_req;
    assign bus.dmem_we  = dmem_we;
    assign state_dbg    = state;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-cycle state/strobe checks plus a retire scoreboard.
module tb_core_sequencer;
    import riscuinho_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [4:0] rd_sel;
    logic       branch_taken;
    logic       ir_we, pc_we, pc_src, rf_we, instret, trap;
    logic [1:0] rd_data_sel;
    logic [2:0] state_dbg;

    core_sequencer_if bus ();

    core_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .rd_sel       (rd_sel),
        .branch_taken (branch_taken),
        .bus          (bus),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .rf_we        (rf_we),
        .rd_data_sel  (rd_data_sel),
        .instret      (instret),
        .state_dbg    (state_dbg),
        .trap         (trap)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;

    // expected retire record: {sel_dont_care, pc_src, rf_we, rd_data_sel}
    logic [4:0] exp_q[$];
    logic [4:0] exp_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // scoreboard: every instret pulse must match the next expected retirement
    always @(negedge clk) begin
        if (instret === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_instret", 32'(instret), 32'd0);
            end else begin
                exp_r = exp_q.pop_front();
                if (exp_r[4])
                    chk("retire_src_rf", 32'({pc_src, rf_we}), 32'(exp_r[3:2]));
                else
                    chk("retire_src_rf_sel", 32'({pc_src, rf_we, rd_data_sel}), 32'(exp_r[3:0]));
            end
        end
    end

    // Drives one instruction from its first FETCH cycle through WB; exp_sel[2]=1 leaves rd_data_sel unchecked.
    task automatic run_instr(input string tag, input logic [6:0] opc, input logic [4:0] rd,
                             input logic bt, input int iw, input int dw, input logic stray,
                             input logic is_mem, input logic exp_we, input logic exp_src,
                             input logic exp_rf, input logic [2:0] exp_sel, input int exp_lat);
        int start;
        start        = cyc;
        opcode       = opc;
        rd_sel       = rd;
        branch_taken = bt;
        exp_q.push_back({exp_sel[2], exp_src, exp_rf, exp_sel[1:0]});
        for (int i = 0; i < iw; i++) begin
            bus.imem_ack = 1'b0;
            bus.dmem_ack = stray;
            #1;
            chk({tag, ".wait_state"}, 32'(state_dbg), 32'(ST_FETCH));
            chk({tag, ".wait_ir_we"}, 32'(ir_we), 32'd0);
            tick();
        end
        bus.imem_ack = 1'b1;
        bus.dmem_ack = stray;
        #1;
        chk({tag, ".fetch_req"}, 32'(bus.imem_req), 32'd1);
        chk({tag, ".fetch_ir_we"}, 32'(ir_we), 32'd1);
        tick();
        bus.imem_ack = stray;
        #1;
        chk({tag, ".decode_state"}, 32'(state_dbg), 32'(ST_DECODE));
        chk({tag, ".decode_ir_we"}, 32'(ir_we), 32'd0);
        tick();
        chk({tag, ".exec_state"}, 32'(state_dbg), 32'(ST_EXEC));
        if (!exp_sel[2]) chk({tag, ".exec_sel"}, 32'(rd_data_sel), 32'(exp_sel[1:0]));
        tick();
        if (is_mem) begin
            for (int i = 0; i < dw; i++) begin
                bus.dmem_ack = 1'b0;
                #1;
                chk({tag, ".mem_wait_state"}, 32'(state_dbg), 32'(ST_MEM));
                chk({tag, ".mem_wait_req"}, 32'(bus.dmem_req), 32'd1);
                chk({tag, ".mem_wait_we"}, 32'(bus.dmem_we), 32'(exp_we));
                tick();
            end
            bus.dmem_ack = 1'b1;
            #1;
            chk({tag, ".mem_ack_req"}, 32'(bus.dmem_req), 32'd1);
            chk({tag, ".mem_ack_we"}, 32'(bus.dmem_we), 32'(exp_we));
            if (!exp_sel[2]) chk({tag, ".mem_sel"}, 32'(rd_data_sel), 32'(exp_sel[1:0]));
            tick();
            bus.dmem_ack = stray;
        end
        #1;
        chk({tag, ".wb_state"}, 32'(state_dbg), 32'(ST_WB));
        chk({tag, ".wb_latency"}, 32'(cyc - start + 1), 32'(exp_lat));
        chk({tag, ".wb_pc_we"}, 32'(pc_we), 32'd1);
        chk({tag, ".wb_pc_src"}, 32'(pc_src), 32'(exp_src));
        chk({tag, ".wb_rf_we"}, 32'(rf_we), 32'(exp_rf));
        chk({tag, ".wb_dmem_req"}, 32'(bus.dmem_req), 32'd0);
        if (!exp_sel[2]) chk({tag, ".wb_sel"}, 32'(rd_data_sel), 32'(exp_sel[1:0]));
        tick();
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        #1;
        chk({tag, ".next_fetch"}, 32'(state_dbg), 32'(ST_FETCH));
        chk({tag, ".next_instret"}, 32'(instret), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        opcode       = 7'd0;
        rd_sel       = 5'd0;
        branch_taken = 1'b0;
        bus.imem_ack = 1'b1;
        bus.dmem_ack = 1'b1;
        tick();
        tick();
        chk("rst.state", 32'(state_dbg), 32'(ST_FETCH));
        chk("rst.imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst.ir_we", 32'(ir_we), 32'd0);
        chk("rst.strobes", 32'({bus.dmem_req, bus.dmem_we, pc_we, pc_src, rf_we, instret, trap}), 32'd0);
        chk("rst.sel", 32'(rd_data_sel), 32'd0);
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        reset        = 1'b0;
        tick();
        chk("rst_release.imem_req", 32'(bus.imem_req), 32'd1);

        //        tag       opcode        rd    bt  iw dw st  mem we src rf  sel     lat
        run_instr("addi",   7'b0010011,  5'd5, 0,  0, 0, 0,  0,  0, 0,  1,  3'b000, 4);
        run_instr("lw",     7'b0000011,  5'd3, 0,  0, 3, 0,  1,  0, 0,  1,  3'b001, 8);
        run_instr("beq_t",  7'b1100011,  5'd7, 1,  0, 0, 0,  0,  0, 1,  0,  3'b100, 4);
        run_instr("beq_nt", 7'b1100011,  5'd7, 0,  0, 0, 0,  0,  0, 0,  0,  3'b100, 4);
        run_instr("jal_x0", 7'b1101111,  5'd0, 0,  0, 0, 0,  0,  0, 1,  0,  3'b010, 4);
        run_instr("jalr",   7'b1100111,  5'd1, 0,  2, 0, 1,  0,  0, 1,  1,  3'b010, 6);
        run_instr("lui",    7'b0110111,  5'd9, 0,  0, 0, 0,  0,  0, 0,  1,  3'b011, 4);
        run_instr("auipc",  7'b0010111,  5'd4, 0,  0, 0, 1,  0,  0, 0,  1,  3'b000, 4);
        run_instr("op_x0",  7'b0110011,  5'd0, 0,  0, 0, 0,  0,  0, 0,  0,  3'b000, 4);
        run_instr("sw",     7'b0100011,  5'd2, 0,  0, 0, 1,  1,  1, 0,  0,  3'b100, 5);
        run_instr("fence",  7'b0001111,  5'd1, 0,  0, 0, 0,  0,  0, 0,  0,  3'b100, 4);
        run_instr("ecall",  7'b1110011,  5'd1, 1,  0, 0, 0,  0,  0, 0,  0,  3'b100, 4);

        // store aborted by reset while in MEM
        opcode       = 7'b0100011;
        rd_sel       = 5'd0;
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        tick();
        chk("abort.mem_state", 32'(state_dbg), 32'(ST_MEM));
        chk("abort.mem_req", 32'(bus.dmem_req), 32'd1);
        chk("abort.mem_we", 32'(bus.dmem_we), 32'd1);
        reset = 1'b1;
        tick();
        chk("abort.state", 32'(state_dbg), 32'(ST_FETCH));
        chk("abort.dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("abort.instret", 32'(instret), 32'd0);
        chk("abort.pc_rf", 32'({pc_we, rf_we}), 32'd0);
        chk("abort.imem_req", 32'(bus.imem_req), 32'd0);
        reset = 1'b0;
        tick();
        chk("abort_release.imem_req", 32'(bus.imem_req), 32'd1);

`ifdef ILLEGAL_TRAP_EN
        opcode       = 7'b1111111;
        rd_sel       = 5'd5;
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        chk("trap.decode_trap", 32'(trap), 32'd0);
        tick();
        for (int i = 0; i < 20; i++) begin
            bus.imem_ack = 1'b1;
            bus.dmem_ack = 1'b1;
            #1;
            chk("trap.state", 32'(state_dbg), 32'(ST_TRAP));
            chk("trap.trap", 32'(trap), 32'd1);
            chk("trap.strobes", 32'({bus.imem_req, ir_we, bus.dmem_req, pc_we, rf_we, instret}), 32'd0);
            tick();
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        reset        = 1'b1;
        tick();
        chk("trap.cleared", 32'(trap), 32'd0);
        reset = 1'b0;
        tick();
`else
        run_instr("illegal", 7'b1111111, 5'd5, 0, 0, 0, 0, 0, 0, 0, 0, 3'b100, 4);
        chk("illegal.trap", 32'(trap), 32'd0);
`endif

        tick();
        tick();
        chk("retire_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
